// File: rtl/sram_pipe_model_if.sv
// Request/response bus of the behavioural SRAM model.
// The master side issues requests; the slave side is the memory model.
interface sram_pipe_model_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  init_done;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram_pipe_model.sv
// Behavioural single-port SRAM with byte enables, a fixed-latency read
// pipeline and an optional post-reset clear sequencer (one word per cycle).
module sram_pipe_model #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 9,
  parameter int READ_LAT     = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input logic              clk,
  input logic              rst,
  sram_pipe_model_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [0:0] {ST_CLEAR, ST_RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;
  logic              clr_we;
  logic              ready_q;
  logic              done_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              wr_acc;

  logic              vld_p  [READ_LAT];
  logic [DATA_W-1:0] data_p [READ_LAT];

  // A request landing on a reset edge is ignored, whatever ready showed.
  assign rd_acc = !rst && bus.req_valid && ready_q && !bus.req_wen;
  assign wr_acc = !rst && bus.req_valid && ready_q &&  bus.req_wen;

  assign bus.req_ready = ready_q;
  assign bus.init_done = done_q;
  assign bus.rsp_valid = vld_p[READ_LAT-1];
  assign bus.rsp_rdata = data_p[READ_LAT-1];

  // Next-state logic: walk clr_cnt over the whole array, then run.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clr_we       = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we       = 1'b1;
        clr_cnt_next = clr_cnt + 1'b1;
        if (&clr_cnt) state_next = ST_RUN;
      end
      default: ;
    endcase
  end

  // State register; ready/init_done are registered so they read 0 on any reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      ready_q <= (state_next == ST_RUN);
      done_q  <= (state_next == ST_RUN);
    end
  end

  // Array writes: clear sequencer has priority, otherwise byte-masked request writes.
  always_ff @(posedge clk) begin
    if (!rst && clr_we) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Read valid shift register; reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < READ_LAT; k++) vld_p[k] <= 1'b0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int k = 1; k < READ_LAT; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // Read data shift register; a stage only loads with valid data, so the last stage holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p[READ_LAT-1] <= '0;
    end else begin
      if (rd_acc) data_p[0] <= mem[bus.req_addr];
      for (int k = 1; k < READ_LAT; k++) begin
        if (vld_p[k-1]) data_p[k] <= data_p[k-1];
      end
    end
  end

  // Protocol checks on the request port.
  always @(posedge clk) begin
    if (!rst && bus.req_valid) begin
      assert (ready_q)
        else $error("sram_pipe_model: req_valid while req_ready=0");
      assert (!$isunknown({bus.req_addr, bus.req_wen}))
        else $error("sram_pipe_model: X on req_addr/req_wen with req_valid=1");
    end
  end
endmodule

// File: tb/tb_sram_pipe_model.sv
// Directed bench for sram_pipe_model: three instances with different
// parameter sets cover clear, latency, byte enables, streaming and reset.
module tb_sram_pipe_model;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  // A: clear on reset, 16 words, 32-bit, latency 4
  sram_pipe_model_if #(.DATA_W(32), .ADDR_W(4)) bus_a ();
  sram_pipe_model #(.DATA_W(32), .ADDR_W(4), .READ_LAT(4), .CLEAR_ON_RST(1))
    dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));

  // B: no clear, 32 words, 8-bit, latency 3
  sram_pipe_model_if #(.DATA_W(8), .ADDR_W(5)) bus_b ();
  sram_pipe_model #(.DATA_W(8), .ADDR_W(5), .READ_LAT(3), .CLEAR_ON_RST(0))
    dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  // C: no clear, 8 words, 16-bit, latency 2
  sram_pipe_model_if #(.DATA_W(16), .ADDR_W(3)) bus_c ();
  sram_pipe_model #(.DATA_W(16), .ADDR_W(3), .READ_LAT(2), .CLEAR_ON_RST(0))
    dut_c (.clk(clk), .rst(rst_c), .bus(bus_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_write(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b1;
    bus_a.req_addr = addr; bus_a.req_wdata = d; bus_a.req_be = be;
    @(negedge clk);
    bus_a.req_valid = 1'b0; bus_a.req_wen = 1'b0;
  endtask

  task automatic a_read(input logic [3:0] addr, output logic [31:0] d, output int lat);
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b0; bus_a.req_addr = addr;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    lat = 1;
    while (!bus_a.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = bus_a.rsp_rdata;
  endtask

  task automatic b_write(input logic [4:0] addr, input logic [7:0] d);
    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_wen = 1'b1;
    bus_b.req_addr = addr; bus_b.req_wdata = d; bus_b.req_be = 1'b1;
    @(negedge clk);
    bus_b.req_valid = 1'b0; bus_b.req_wen = 1'b0;
  endtask

  task automatic b_read(input logic [4:0] addr, output logic [7:0] d, output int lat);
    @(negedge clk);
    bus_b.req_valid = 1'b1; bus_b.req_wen = 1'b0; bus_b.req_addr = addr;
    @(negedge clk);
    bus_b.req_valid = 1'b0;
    lat = 1;
    while (!bus_b.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = bus_b.rsp_rdata;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] da;
    logic [7:0]  db;
    int          lat;
    int          n;
    int          seen;
    int          rd_idx;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.req_valid = 1'b0; bus_a.req_wen = 1'b0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0; bus_a.req_be = '0;
    bus_b.req_valid = 1'b0; bus_b.req_wen = 1'b0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0; bus_b.req_be = '0;
    bus_c.req_valid = 1'b0; bus_c.req_wen = 1'b0; bus_c.req_addr = '0;
    bus_c.req_wdata = '0; bus_c.req_be = '0;
    repeat (3) @(negedge clk);
    rst_b = 1'b0; rst_c = 1'b0;

    // Test 1: reset clear on A, 16 cycles of ready=0, then all zero
    @(negedge clk);
    rst_a = 1'b0;
    check("a_rst_ready", 32'(bus_a.req_ready), 32'd0);
    check("a_rst_rspv",  32'(bus_a.rsp_valid), 32'd0);
    check("a_rst_rdata", bus_a.rsp_rdata,      32'd0);
    check("a_rst_done",  32'(bus_a.init_done), 32'd0);
    n = 0;
    while (bus_a.req_ready == 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("a_clr_cycles", 32'(n), 32'd16);
    check("a_init_done",  32'(bus_a.init_done), 32'd1);
    for (int i = 0; i < 16; i++) begin
      a_read(4'(i), da, lat);
      check("a_clr_lat",  32'(lat), 32'd4);
      check("a_clr_data", da, 32'd0);
    end

    // Test 3: byte enables on A
    a_write(4'd2, 32'h11223344, 4'hF);
    a_write(4'd2, 32'hAABBCCDD, 4'b0101);
    a_read(4'd2, da, lat);
    check("a_be_merge", da, 32'h11BB33DD);
    a_write(4'd2, 32'hFFFFFFFF, 4'h0);
    a_read(4'd2, da, lat);
    check("a_be_zero", da, 32'h11BB33DD);
    a_write(4'd7, 32'h0000BEEF, 4'b0011);
    a_read(4'd7, da, lat);
    check("a_be_low", da, 32'h0000BEEF);
    @(negedge clk);
    check("a_hold_vld",  32'(bus_a.rsp_valid), 32'd0);
    check("a_hold_data", bus_a.rsp_rdata, 32'h0000BEEF);

    // Test 5: reset two cycles after a read is accepted on A
    a_write(4'd0, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_wen = 1'b0; bus_a.req_addr = 4'd0;
    @(negedge clk);
    bus_a.req_valid = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("a_mid_rdata", bus_a.rsp_rdata, 32'd0);
    seen = 0;
    n = 0;
    while (bus_a.req_ready == 1'b0 && n < 40) begin
      if (bus_a.rsp_valid) seen++;
      n++;
      @(negedge clk);
    end
    repeat (6) begin
      if (bus_a.rsp_valid) seen++;
      @(negedge clk);
    end
    check("a_mid_clr_cycles", 32'(n), 32'd16);
    check("a_mid_no_rsp", 32'(seen), 32'd0);
    a_read(4'd0, da, lat);
    check("a_mid_addr0", da, 32'd0);
    a_read(4'd2, da, lat);
    check("a_mid_addr2", da, 32'd0);

    // Test 2: latency 3 on B
    b_write(5'h10, 8'hA5);
    b_read(5'h10, db, lat);
    check("b_lat",  32'(lat), 32'd3);
    check("b_data", 32'(db),  32'hA5);

    // Test 6: B keeps contents over reset and is ready right away
    b_write(5'd3, 8'h5A);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    check("b_rst_ready", 32'(bus_b.req_ready), 32'd0);
    check("b_rst_rdata", 32'(bus_b.rsp_rdata), 32'd0);
    check("b_rst_done",  32'(bus_b.init_done), 32'd0);
    @(negedge clk);
    check("b_ready_first", 32'(bus_b.req_ready), 32'd1);
    check("b_done_first",  32'(bus_b.init_done), 32'd1);
    b_read(5'd3, db, lat);
    check("b_keep_data", 32'(db), 32'h5A);
    b_read(5'h10, db, lat);
    check("b_keep_data2", 32'(db), 32'hA5);

    // Test 4: streaming reads on C, latency 2
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus_c.req_valid = 1'b1; bus_c.req_wen = 1'b1; bus_c.req_be = 2'b11;
      bus_c.req_addr = 3'(i); bus_c.req_wdata = 16'h1000 + 16'(i) * 16'h0111;
    end
    rd_idx = 0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (bus_c.rsp_valid) begin
        check("c_stream_slot", 32'(t), 32'(rd_idx + 2));
        check("c_stream_data", 32'(bus_c.rsp_rdata), 32'(16'h1000 + 16'(rd_idx) * 16'h0111));
        rd_idx++;
      end
      bus_c.req_wen   = 1'b0;
      bus_c.req_valid = (t < 8);
      bus_c.req_addr  = 3'(t);
    end
    bus_c.req_valid = 1'b0;
    check("c_stream_count", 32'(rd_idx), 32'd8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
